// File: rtl/store_buffer.sv
// Write-behind store buffer between the datapath and data memory.
// Stores queue in a circular FIFO and drain in program order; loads forward from the youngest match.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  input  logic [31:0]              cpu_a,
  input  logic [31:0]              cpu_wd,
  output logic [31:0]              cpu_rd,
  output logic                     cpu_stall,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [31:0]              mem_a,
  output logic [31:0]              mem_wd,
  input  logic [31:0]              mem_rd,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_drain;
  logic          w_accept;
  logic          w_hit;
  logic [31:0]   w_fwd_data;
  logic [PW-1:0] w_slot;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  // A load owns the memory port this cycle, so it blocks the drain.
  assign w_drain  = !w_empty && mem_ready && !cpu_re;
  assign w_accept = cpu_we && (!w_full || w_drain);

  assign cpu_stall = cpu_we && !w_accept;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;

  assign mem_we = w_drain;
  assign mem_a  = w_drain ? {r_addr[r_head], 2'b00} : cpu_a;
  assign mem_wd = w_drain ? r_data[r_head] : 32'h0;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = 32'h0;
    w_slot     = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_slot] == cpu_a[31:2])) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[w_slot];
      end
    end
  end

  always_comb begin
    cpu_rd = 32'h0;
    if (cpu_re && !cpu_we) begin
      cpu_rd = w_hit ? w_fwd_data : mem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      if (w_accept && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (w_drain && !w_accept) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage is left unreset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr[r_tail] <= cpu_a[31:2];
      r_data[r_tail] <= cpu_wd;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model checked every cycle.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_a = 32'h0;
  logic [31:0] cpu_wd = 32'h0;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;
  logic        full;
  logic [$clog2(DEPTH):0] count;

  logic [31:0] dmem [64];
  ent_t        sbq [$];
  int          m_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  ent_t        m_e;
  logic        m_drain;
  logic        m_accept;
  logic [31:0] m_rd;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (empty !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(empty), 32'h1);
  endtask

  always @(negedge reset_n) begin
    sbq.delete();
    m_count = 0;
  end

  // Reference model: pops expected drains, pushes accepted stores.
  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete();
      m_count = 0;
    end
    m_drain  = (m_count > 0) && mem_ready && !cpu_re;
    m_accept = cpu_we && ((m_count < DEPTH) || m_drain);
    chk("m_count", 32'(count), 32'(m_count));
    chk("m_empty", 32'(empty), 32'(m_count == 0));
    chk("m_full", 32'(full), 32'(m_count == DEPTH));
    chk("m_stall", 32'(cpu_stall), 32'(cpu_we && !m_accept));
    chk("m_mem_we", 32'(mem_we), 32'(m_drain));
    m_rd = 32'h0;
    if (cpu_re && !cpu_we) begin
      m_rd = dmem[cpu_a[7:2]];
      foreach (sbq[i]) if (sbq[i].a == cpu_a[31:2]) m_rd = sbq[i].d;
    end
    chk("m_cpu_rd", cpu_rd, m_rd);
    if (m_drain) begin
      m_e = sbq.pop_front();
      chk("m_drain_a", mem_a, {m_e.a, 2'b00});
      chk("m_drain_wd", mem_wd, m_e.d);
    end else begin
      chk("m_idle_a", mem_a, cpu_a);
      chk("m_idle_wd", mem_wd, 32'h0);
    end
    if (reset_n) begin
      if (m_accept) begin
        m_e.a = cpu_a[31:2];
        m_e.d = cpu_wd;
        sbq.push_back(m_e);
      end
      if (m_accept && !m_drain) m_count++;
      else if (m_drain && !m_accept) m_count--;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'h1000_0000 | 32'(i);
    dmem[9] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    #2 reset_n = 1'b1;

    // Single store drains on the following cycle.
    cyc(); mem_ready = 1'b1; cpu_we = 1'b1; cpu_a = 32'h4; cpu_wd = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("st_stall", 32'(cpu_stall), 32'h0);
    cyc(); cpu_we = 1'b0;
    @(negedge clk);
    chk("dr_we", 32'(mem_we), 32'h1);
    chk("dr_a", mem_a, 32'h4);
    chk("dr_wd", mem_wd, 32'hA5A5_A5A5);
    cyc(); cpu_re = 1'b1; cpu_a = 32'h4;
    @(negedge clk);
    chk("dr_empty", 32'(empty), 32'h1);
    chk("dr_dmem", cpu_rd, 32'hA5A5_A5A5);

    // Youngest of two stores to the same word is forwarded.
    cyc(); cpu_re = 1'b0; mem_ready = 1'b0; cpu_we = 1'b1; cpu_a = 32'h8; cpu_wd = 32'h11;
    cyc(); cpu_wd = 32'h22;
    cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_a = 32'h8;
    @(negedge clk);
    chk("fwd_young", cpu_rd, 32'h22);
    chk("fwd_we", 32'(mem_we), 32'h0);
    chk("fwd_count", 32'(count), 32'h2);

    // Miss goes to memory.
    cyc(); cpu_re = 1'b0; cpu_we = 1'b1; cpu_a = 32'h20; cpu_wd = 32'h2020;
    cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_a = 32'h24;
    @(negedge clk);
    chk("miss_rd", cpu_rd, 32'hDEAD_BEEF);
    chk("miss_a", mem_a, 32'h24);
    chk("miss_we", 32'(mem_we), 32'h0);
    chk("miss_count", 32'(count), 32'h3);

    // Store and load together: load ignored.
    cyc(); cpu_we = 1'b1; cpu_re = 1'b1; cpu_a = 32'h8; cpu_wd = 32'h33;
    @(negedge clk);
    chk("both_rd", cpu_rd, 32'h0);
    chk("both_stall", 32'(cpu_stall), 32'h0);
    cyc(); cpu_we = 1'b0; cpu_re = 1'b0;
    @(negedge clk);
    chk("nore_rd", cpu_rd, 32'h0);
    chk("both_full", 32'(full), 32'h1);
    cyc(); cpu_re = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("ld_blocks_drain", 32'(mem_we), 32'h0);
    chk("fwd_full", cpu_rd, 32'h33);
    cyc(); cpu_re = 1'b0;
    wait_empty();
    cyc(); cpu_re = 1'b1; cpu_a = 32'h8;
    @(negedge clk);
    chk("order_final", cpu_rd, 32'h33);

    // Fill, stall, then accept into the full buffer while draining.
    cyc(); cpu_re = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_a = 32'h10 + 32'(4 * i); cpu_wd = 32'h100 + 32'(i);
      cyc();
    end
    cpu_a = 32'h50; cpu_wd = 32'h55;
    @(negedge clk);
    chk("full_flag", 32'(full), 32'h1);
    chk("full_stall", 32'(cpu_stall), 32'h1);
    chk("full_count", 32'(count), 32'h4);
    cyc(); mem_ready = 1'b1;
    @(negedge clk);
    chk("swap_stall", 32'(cpu_stall), 32'h0);
    chk("swap_a", mem_a, 32'h10);
    chk("swap_count", 32'(count), 32'h4);
    cyc(); cpu_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("swap_after", 32'(count), 32'h4);
    cyc(); mem_ready = 1'b1;
    wait_empty();

    // Duplicate addresses drain in order.
    cyc(); mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cpu_we = 1'b1; cpu_a = 32'hC; cpu_wd = 32'(i);
      cyc();
    end
    cpu_we = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("dup_first_a", mem_a, 32'hC);
    chk("dup_first_wd", mem_wd, 32'h1);
    wait_empty();
    cyc(); cpu_re = 1'b1; cpu_a = 32'hC;
    @(negedge clk);
    chk("dup_final", cpu_rd, 32'h3);

    // Reset mid-operation discards pending stores.
    cyc(); cpu_re = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_a = 32'h40 + 32'(4 * i); cpu_wd = 32'hBAD0 + 32'(i);
      cyc();
    end
    cpu_we = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'h3);
    cyc(); reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_we", 32'(mem_we), 32'h0);
    #1 reset_n = 1'b1;
    cyc(); mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 32'(mem_we), 32'h0);
    cyc(); cpu_re = 1'b1; cpu_a = 32'h40;
    @(negedge clk);
    chk("post_rst_d0", cpu_rd, 32'h1000_0010);
    cyc(); cpu_a = 32'h48;
    @(negedge clk);
    chk("post_rst_d2", cpu_rd, 32'h1000_0012);
    cyc(); cpu_re = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
